obj_scheduler: RTL and testbench
================================

# obj_scheduler

Per-pixel object scheduler for the VGA sprite path (640x480). It holds the positions of N 32x32 objects in double-buffered registers and commits host updates only at frame boundaries so objects never tear mid-frame. For every scanned pixel it decides which enabled object owns that pixel, with the lowest index winning, and emits that object's id and its 5-bit local coordinates to the sprite ROM and colour stage. An optional collision monitor flags overlap between object 0 (the player) and any other object.

## Interface
- N_OBJ, 4: number of objects; range 2..8.
- clk  in  1: pixel clock; all logic on the rising edge.
- reset  in  1: synchronous, active-high.
- global_pixel_x  in  10: current scan x.
- global_pixel_y  in  10: current scan y.
- pixel_valid  in  1: high inside the active area.
- frame_start  in  1: one-cycle pulse at the start of vertical blanking.
- wr_en  in  1: write strobe into the shadow bank.
- wr_idx  in  3: target object (only the low bits are used; writes with wr_idx ≥ N_OBJ are ignored).
- wr_x, wr_y  in  10 each: top-left position.
- wr_obj_en  in  1: object enable.
- commit_req  in  1: request a shadow→active copy.
- commit_pending  out  1: a commit has been requested and not yet applied.
- commit_ack  out  1: one-cycle pulse when the copy happens.
- hit  out  1: some enabled object covers the pixel.
- obj_id  out  3: winning object index.
- obj_pixel_x, obj_pixel_y  out  5 each: local coordinates of the winner.
- collision  out  1: collision result for the previous frame.

## Operation
- **Reset:**
  - Shadow and active banks cleared: x = y = 0, enable = 0.
  - commit_pending = 0 and commit_ack = 0.
  - hit = 0, obj_id = 0, obj_pixel_x = obj_pixel_y = 0, collision = 0.
  - Internal pipeline valid bits and the collision latch cleared.
- **Shadow writes:** wr_en loads {wr_x, wr_y, wr_obj_en} into shadow[wr_idx] at the next edge. Shadow writes are always accepted, pending or not.
- **Commit FSM** (states IDLE, PENDING):
  - IDLE → PENDING on commit_req.
  - In PENDING, on frame_start: copy the whole shadow bank to the active bank, pulse commit_ack, return to IDLE.
  - commit_req and frame_start in the same cycle while in IDLE: the commit is applied at that same edge (ack pulses). This counts as one commit.
  - commit_req while already PENDING: no effect.
  - wr_en in the same cycle as the copy: the copy uses the pre-write shadow value; the write lands in shadow for the next commit.
  - commit_pending is high exactly in PENDING.
- **Hit test (per object i, against the active bank):**
  - Object i is in range when en_i, x ≥ X_i, x < X_i + 32, y ≥ Y_i and y < Y_i + 32.
  - The sums are formed in 11 bits, so objects near x/y = 1023 do not wrap to 0.
  - Local offset = (x − X_i)[4:0] and (y − Y_i)[4:0].
- **Priority:** the lowest-index in-range object wins. hit is forced to 0 when pixel_valid was low. When hit = 0, obj_id and the local coordinates are 0.
- The active bank changes only at commit, never in the active area (frame_start falls in blanking).

## Timing
- Two-stage pipeline with latency 2 cycles from global_pixel_x/y/pixel_valid to hit/obj_id/obj_pixel_x/y:
  - Stage 1 registers the per-object range bits and offsets.
  - Stage 2 registers the priority-encoded result.
- Throughput: one pixel per cycle, with no stalls.
- commit_ack is high for the single cycle after the edge on which frame_start was sampled in PENDING. The new positions affect the hit outputs two cycles later.
- Reset asserted mid-frame or mid-commit: all state returns to reset values at that edge. A pending commit is dropped.

## Configuration
- **OBJ_COLLISION_EN defined:**
  - Each cycle, if the stage-1 range bit of object 0 is set and the range bit of any other enabled object is also set (with pixel_valid), a sticky latch is set.
  - On frame_start: collision takes the latch value, and the latch clears. If an overlap occurs on the same cycle as frame_start, it is counted into the new latch.
  - collision holds its value for the whole next frame.
- **Not defined:** no latch is built and collision is tied to 0.

## Test plan
- **Reset values:** reset for 2 cycles → all outputs 0. A scan over the full frame gives hit = 0 everywhere.
- **Single object:** write obj1 = (100, 50, en), commit_req, then frame_start → commit_ack pulses. Pixel (131, 81) gives hit = 1, obj_id = 1, local (31, 31) two cycles later. Pixels (132, 81) and (99, 50) give hit = 0.
- **Priority:** obj0 = (200, 200) and obj2 = (210, 210), both enabled → pixel (215, 215) gives obj_id = 0, local (15, 15). Disable obj0 and commit → obj_id = 2, local (5, 5).
- **Deferred commit:** write obj1 x = 300 with commit_req mid-frame → output still uses the old x until frame_start. A wr_en on the frame_start cycle is not visible until the next commit.
- **Edge wrap:** obj3 = (1010, 0) → pixel x = 2 gives hit = 0, and pixel x = 1015 is in range (local x = 5) when driven with pixel_valid.
- **Collision (OBJ_COLLISION_EN):** obj0 and obj1 overlap at (400, 300) in frame N → collision = 1 after the frame_start ending N. Move obj1 away and run frame N+1 → collision = 0 after the next frame_start.

Source files
------------

// File: rtl/obj_scheduler_if.sv
// Pixel scan, host write/commit bus and object result bundle
// shared by obj_scheduler and its host/sprite stages.
interface obj_scheduler_if;
   logic [9:0] global_pixel_x;
   logic [9:0] global_pixel_y;
   logic       pixel_valid;
   logic       frame_start;
   logic       wr_en;
   logic [2:0] wr_idx;
   logic [9:0] wr_x;
   logic [9:0] wr_y;
   logic       wr_obj_en;
   logic       commit_req;
   logic       commit_pending;
   logic       commit_ack;
   logic       hit;
   logic [2:0] obj_id;
   logic [4:0] obj_pixel_x;
   logic [4:0] obj_pixel_y;
   logic       collision;

   modport master (
      output global_pixel_x, global_pixel_y, pixel_valid,
      output frame_start, wr_en, wr_idx, wr_x, wr_y,
      output wr_obj_en, commit_req,
      input  commit_pending, commit_ack, hit, obj_id,
      input  obj_pixel_x, obj_pixel_y, collision
   );

   modport slave (
      input  global_pixel_x, global_pixel_y, pixel_valid,
      input  frame_start, wr_en, wr_idx, wr_x, wr_y,
      input  wr_obj_en, commit_req,
      output commit_pending, commit_ack, hit, obj_id,
      output obj_pixel_x, obj_pixel_y, collision
   );
endinterface

// File: rtl/obj_scheduler.sv
// Per-pixel object scheduler: double-buffered 32x32 object positions,
// frame-boundary commit, 2-stage lowest-index-wins hit pipeline.
// Optional macro OBJ_COLLISION_EN builds the object-0 collision monitor.
module obj_scheduler #(
   parameter int N_OBJ = 4
) (
   input logic            clk,
   input logic            reset,
   obj_scheduler_if.slave bus
);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t state_q;
   logic   ack_q;
   logic   commit_fire;

   logic [N_OBJ-1:0][9:0] sh_x_q, sh_x_d;
   logic [N_OBJ-1:0][9:0] sh_y_q, sh_y_d;
   logic [N_OBJ-1:0]      sh_en_q, sh_en_d;
   logic [N_OBJ-1:0][9:0] act_x_q, act_x_d;
   logic [N_OBJ-1:0][9:0] act_y_q, act_y_d;
   logic [N_OBJ-1:0]      act_en_q, act_en_d;

   logic [10:0]           px, py;
   logic [N_OBJ-1:0]      rng_q, rng_d;
   logic [N_OBJ-1:0][4:0] offx_q, offx_d;
   logic [N_OBJ-1:0][4:0] offy_q, offy_d;
   logic                  v1_q;

   logic       hit_q, hit_d;
   logic [2:0] id_q, id_d;
   logic [4:0] lx_q, lx_d;
   logic [4:0] ly_q, ly_d;

   // A request arriving with frame_start commits on that same edge.
   assign commit_fire = bus.frame_start &&
                        (state_q == PENDING || bus.commit_req);

   // Commit FSM with registered ack pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.commit_req && bus.frame_start)
                  ack_q <= 1'b1;
               else if (bus.commit_req)
                  state_q <= PENDING;
            end
            PENDING: begin
               if (bus.frame_start) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Shadow writes and shadow->active copy (copy sees pre-write shadow).
   always_comb begin
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      sh_en_d  = sh_en_q;
      act_x_d  = act_x_q;
      act_y_d  = act_y_q;
      act_en_d = act_en_q;
      if (commit_fire) begin
         act_x_d  = sh_x_q;
         act_y_d  = sh_y_q;
         act_en_d = sh_en_q;
      end
      for (int i = 0; i < N_OBJ; i++) begin
         if (bus.wr_en && int'(bus.wr_idx) == i) begin
            sh_x_d[i]  = bus.wr_x;
            sh_y_d[i]  = bus.wr_y;
            sh_en_d[i] = bus.wr_obj_en;
         end
      end
   end

   // Shadow and active bank registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_x_q   <= '0;
         sh_y_q   <= '0;
         sh_en_q  <= '0;
         act_x_q  <= '0;
         act_y_q  <= '0;
         act_en_q <= '0;
      end else begin
         sh_x_q   <= sh_x_d;
         sh_y_q   <= sh_y_d;
         sh_en_q  <= sh_en_d;
         act_x_q  <= act_x_d;
         act_y_q  <= act_y_d;
         act_en_q <= act_en_d;
      end
   end

   assign px = {1'b0, bus.global_pixel_x};
   assign py = {1'b0, bus.global_pixel_y};

   // 11-bit bounds so objects near 1023 never wrap to 0.
   for (genvar i = 0; i < N_OBJ; i++) begin : g_rng
      logic [10:0] lo_x, lo_y;
      assign lo_x = {1'b0, act_x_q[i]};
      assign lo_y = {1'b0, act_y_q[i]};
      assign rng_d[i] = act_en_q[i] &&
                        px >= lo_x && px < lo_x + 11'd32 &&
                        py >= lo_y && py < lo_y + 11'd32;
      assign offx_d[i] = bus.global_pixel_x[4:0] - act_x_q[i][4:0];
      assign offy_d[i] = bus.global_pixel_y[4:0] - act_y_q[i][4:0];
   end

   // Stage 1: per-object range bits and local offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         rng_q  <= '0;
         offx_q <= '0;
         offy_q <= '0;
         v1_q   <= 1'b0;
      end else begin
         rng_q  <= rng_d;
         offx_q <= offx_d;
         offy_q <= offy_d;
         v1_q   <= bus.pixel_valid;
      end
   end

   // Lowest index wins: scan high to low so the last match sticks.
   always_comb begin
      hit_d = 1'b0;
      id_d  = '0;
      lx_d  = '0;
      ly_d  = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (v1_q && rng_q[i]) begin
            hit_d = 1'b1;
            id_d  = 3'(i);
            lx_d  = offx_q[i];
            ly_d  = offy_q[i];
         end
      end
   end

   // Stage 2: registered priority result.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_q <= 1'b0;
         id_q  <= '0;
         lx_q  <= '0;
         ly_q  <= '0;
      end else begin
         hit_q <= hit_d;
         id_q  <= id_d;
         lx_q  <= lx_d;
         ly_q  <= ly_d;
      end
   end

   assign bus.commit_pending = (state_q == PENDING);
   assign bus.commit_ack     = ack_q;
   assign bus.hit            = hit_q;
   assign bus.obj_id         = id_q;
   assign bus.obj_pixel_x    = lx_q;
   assign bus.obj_pixel_y    = ly_q;

`ifdef OBJ_COLLISION_EN
   logic overlap;
   logic latch_q, latch_d;
   logic coll_q, coll_d;

   assign overlap = v1_q && rng_q[0] && (|rng_q[N_OBJ-1:1]);

   // Sticky overlap latch, handed to collision at each frame_start.
   always_comb begin
      latch_d = latch_q | overlap;
      coll_d  = coll_q;
      if (bus.frame_start) begin
         coll_d  = latch_q;
         latch_d = overlap;
      end
   end

   // Collision latch and per-frame result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch_q <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         latch_q <= latch_d;
         coll_q  <= coll_d;
      end
   end

   assign bus.collision = coll_q;
`else
   assign bus.collision = 1'b0;
`endif

endmodule

// File: tb/tb_obj_scheduler.sv
// Self-checking bench for obj_scheduler: behavioural model,
// per-cycle compare, directed literal checks and random traffic.
module tb_obj_scheduler;

   localparam int N = 4;

   logic clk;
   logic reset;
   obj_scheduler_if bus ();

   obj_scheduler #(.N_OBJ(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit hit;
      int id;
      int lx;
      int ly;
      bit ovl;
   } res_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   m_sx[N], m_sy[N], m_ax[N], m_ay[N];
   bit   m_sen[N], m_aen[N];
   bit   m_pend, m_ack, m_latch, m_coll, fire;
   res_t s1, eo;
   bit   started = 0;

   task automatic chk(string n, int a, int e);
      n_cmp++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d @%0t", n, a, e, $time);
      end
   endtask

   function automatic res_t calc(int x, int y, bit v);
      res_t r;
      bit   inr[N];
      r = '{0, 0, 0, 0, 0};
      for (int i = 0; i < N; i++)
         inr[i] = m_aen[i] && x >= m_ax[i] && x < m_ax[i] + 32 &&
                  y >= m_ay[i] && y < m_ay[i] + 32;
      for (int i = 0; i < N; i++) begin
         if (v && inr[i] && !r.hit) begin
            r.hit = 1;
            r.id  = i;
            r.lx  = x - m_ax[i];
            r.ly  = y - m_ay[i];
         end
      end
      for (int i = 1; i < N; i++)
         if (v && inr[0] && inr[i]) r.ovl = 1;
      return r;
   endfunction

   // Reference model, advanced on every rising edge.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_sen[i] = 0;
            m_ax[i] = 0; m_ay[i] = 0; m_aen[i] = 0;
         end
         s1 = '{0, 0, 0, 0, 0};
         eo = '{0, 0, 0, 0, 0};
         m_pend = 0; m_ack = 0; m_latch = 0; m_coll = 0;
      end else begin
         res_t nw;
         bit   ovl;
         nw  = calc(int'(bus.global_pixel_x),
                    int'(bus.global_pixel_y), bus.pixel_valid);
         ovl = s1.ovl;
         eo  = s1;
         s1  = nw;
`ifdef OBJ_COLLISION_EN
         if (bus.frame_start) begin
            m_coll  = m_latch;
            m_latch = ovl;
         end else begin
            m_latch = m_latch | ovl;
         end
`else
         m_coll = ovl & 1'b0;
`endif
         fire  = bus.frame_start && (m_pend || bus.commit_req);
         m_ack = fire;
         if (fire) begin
            for (int i = 0; i < N; i++) begin
               m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aen[i] = m_sen[i];
            end
            m_pend = 0;
         end else if (bus.commit_req) begin
            m_pend = 1;
         end
         if (bus.wr_en && int'(bus.wr_idx) < N) begin
            m_sx[bus.wr_idx]  = int'(bus.wr_x);
            m_sy[bus.wr_idx]  = int'(bus.wr_y);
            m_sen[bus.wr_idx] = bus.wr_obj_en;
         end
      end
      started = 1;
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (started) begin
         chk("hit", int'(bus.hit), int'(eo.hit));
         chk("obj_id", int'(bus.obj_id), eo.id);
         chk("obj_px", int'(bus.obj_pixel_x), eo.lx);
         chk("obj_py", int'(bus.obj_pixel_y), eo.ly);
         chk("pending", int'(bus.commit_pending), int'(m_pend));
         chk("ack", int'(bus.commit_ack), int'(m_ack));
         chk("collision", int'(bus.collision), int'(m_coll));
      end
   end

   task automatic wr(int idx, int x, int y, bit en);
      bus.wr_en     = 1'b1;
      bus.wr_idx    = 3'(idx);
      bus.wr_x      = 10'(x);
      bus.wr_y      = 10'(y);
      bus.wr_obj_en = en;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic commit_now(string n);
      bus.commit_req  = 1'b1;
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.commit_req  = 1'b0;
      bus.frame_start = 1'b0;
      chk({n, "_ack"}, int'(bus.commit_ack), 1);
   endtask

   task automatic fs_pulse();
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   task automatic probe(int x, int y, bit h, int id,
                        int lx, int ly, string n);
      bus.global_pixel_x = 10'(x);
      bus.global_pixel_y = 10'(y);
      bus.pixel_valid    = 1'b1;
      @(negedge clk);
      bus.pixel_valid = 1'b0;
      @(negedge clk);
      chk({n, "_hit"}, int'(bus.hit), int'(h));
      chk({n, "_id"}, int'(bus.obj_id), id);
      chk({n, "_lx"}, int'(bus.obj_pixel_x), lx);
      chk({n, "_ly"}, int'(bus.obj_pixel_y), ly);
   endtask

   initial begin
      int k;
      reset              = 1'b1;
      bus.global_pixel_x = '0;
      bus.global_pixel_y = '0;
      bus.pixel_valid    = 1'b0;
      bus.frame_start    = 1'b0;
      bus.wr_en          = 1'b0;
      bus.wr_idx         = '0;
      bus.wr_x           = '0;
      bus.wr_y           = '0;
      bus.wr_obj_en      = 1'b0;
      bus.commit_req     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_hit", int'(bus.hit), 0);
      chk("rst_id", int'(bus.obj_id), 0);
      chk("rst_pend", int'(bus.commit_pending), 0);
      chk("rst_ack", int'(bus.commit_ack), 0);
      chk("rst_coll", int'(bus.collision), 0);
      reset = 1'b0;

      // Sparse scan with nothing enabled.
      for (int i = 0; i < 200; i++) begin
         bus.global_pixel_x = 10'($urandom_range(0, 639));
         bus.global_pixel_y = 10'($urandom_range(0, 479));
         bus.pixel_valid    = 1'b1;
         @(negedge clk);
      end
      bus.pixel_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Single object, commit via PENDING.
      wr(1, 100, 50, 1);
      bus.commit_req = 1'b1;
      @(negedge clk);
      bus.commit_req = 1'b0;
      chk("single_pend", int'(bus.commit_pending), 1);
      fs_pulse();
      chk("single_ack", int'(bus.commit_ack), 1);
      chk("single_pend0", int'(bus.commit_pending), 0);
      probe(131, 81, 1, 1, 31, 31, "single_in");
      probe(132, 81, 0, 0, 0, 0, "single_rx");
      probe(99, 50, 0, 0, 0, 0, "single_lx");

      // Priority between obj0 and obj2.
      wr(0, 200, 200, 1);
      wr(2, 210, 210, 1);
      commit_now("prio");
      probe(215, 215, 1, 0, 15, 15, "prio0");
      wr(0, 200, 200, 0);
      commit_now("prio_dis");
      probe(215, 215, 1, 2, 5, 5, "prio2");

      // Deferred commit and write on the commit edge.
      wr(1, 300, 50, 1);
      bus.commit_req = 1'b1;
      @(negedge clk);
      bus.commit_req = 1'b0;
      probe(131, 81, 1, 1, 31, 31, "defer_old");
      bus.frame_start = 1'b1;
      wr(1, 500, 50, 1);
      bus.frame_start = 1'b0;
      probe(301, 51, 1, 1, 1, 1, "defer_new");
      commit_now("defer2");
      probe(501, 51, 1, 1, 1, 1, "defer_wr");
      probe(301, 51, 0, 0, 0, 0, "defer_gone");

      // Right-edge object must not wrap to x = 0.
      wr(3, 1010, 0, 1);
      commit_now("wrap");
      probe(2, 0, 0, 0, 0, 0, "wrap_lo");
      probe(1015, 0, 1, 3, 5, 0, "wrap_hi");

`ifdef OBJ_COLLISION_EN
      wr(0, 400, 300, 1);
      wr(1, 410, 310, 1);
      commit_now("coll");
      probe(415, 315, 1, 0, 15, 15, "coll_px");
      fs_pulse();
      chk("coll_set", int'(bus.collision), 1);
      wr(1, 600, 400, 1);
      commit_now("coll_mv");
      probe(415, 315, 1, 0, 15, 15, "coll_px2");
      fs_pulse();
      chk("coll_clr", int'(bus.collision), 0);
`endif

      // Random traffic with a mid-run reset.
      for (int c = 0; c < 4000; c++) begin
         reset         = (c == 2000 || c == 2001);
         bus.wr_en     = ($urandom_range(0, 9) == 0);
         bus.wr_idx    = 3'($urandom_range(0, 7));
         bus.wr_x      = ($urandom_range(0, 5) == 0) ?
                         10'($urandom_range(990, 1023)) :
                         10'($urandom_range(0, 639));
         bus.wr_y      = ($urandom_range(0, 5) == 0) ?
                         10'($urandom_range(990, 1023)) :
                         10'($urandom_range(0, 479));
         bus.wr_obj_en = ($urandom_range(0, 3) != 0);
         bus.commit_req  = ($urandom_range(0, 19) == 0);
         bus.frame_start = ((c % 97) == 96);
         k = int'($urandom_range(0, N - 1));
         bus.global_pixel_x =
            10'((m_ax[k] + int'($urandom_range(0, 40)) - 4) & 1023);
         bus.global_pixel_y =
            10'((m_ay[k] + int'($urandom_range(0, 40)) - 4) & 1023);
         bus.pixel_valid = ($urandom_range(0, 7) != 0);
         @(negedge clk);
      end
      reset           = 1'b0;
      bus.wr_en       = 1'b0;
      bus.commit_req  = 1'b0;
      bus.frame_start = 1'b0;
      bus.pixel_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
